if_stage: RTL

Instruction fetch stage. It owns the architectural fetch PC and issues in-order word fetches to the instruction memory over a request/grant/response handshake. It buffers returned instructions in a small FIFO and presents them to the decode stage as the `inst`/`pc`/`pc4` triple that decode consumes, with valid/ready flow control. It accepts PC redirects from the execute stage and discards every in-flight and buffered fetch that is older than the redirect.

---
 rtl/if_stage.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/if_stage.sv
// Instruction fetch: owns the fetch PC, issues credit-limited in-order word fetches and buffers replies for decode.
// Grant at N, response at N+1, word at decode at N+2; fetches stop when buffered plus in-flight words fill the FIFO.

// Small circular FIFO; flush empties it without touching storage, pop-and-push when full is allowed.
module if_stage_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic [W-1:0]               push_dat_i,
  input  logic                       pop_i,
  output logic [W-1:0]               head_dat_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_pop, do_push;

  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && ((count_q != CW'(DEPTH)) || do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_dat_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  assign head_dat_o = mem_q[rd_ptr_q];
  assign count_o    = count_q;
endmodule

module if_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc4
);
  localparam int CW = $clog2(FIFO_DEPTH+1);

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] pc4;
  } id_entry_t;

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] discard_q, discard_d;
  logic [CW-1:0] outst, outst_after, count;
  logic [CW:0]   credit;
  logic          grant, resp, drop, keep, pop;
  logic [31:0]   pend_pc;
  id_entry_t     push_ent, head_ent;

  // Pending-PC queue occupancy is the outstanding-fetch count; it is never flushed.
  if_stage_fifo #(.W(32), .DEPTH(FIFO_DEPTH)) u_pend (
    .clk        (clk),
    .rst        (rst),
    .flush_i    (1'b0),
    .push_i     (grant),
    .push_dat_i (fetch_pc_q),
    .pop_i      (resp),
    .head_dat_o (pend_pc),
    .count_o    (outst)
  );

  if_stage_fifo #(.W($bits(id_entry_t)), .DEPTH(FIFO_DEPTH)) u_out (
    .clk        (clk),
    .rst        (rst),
    .flush_i    (redirect_en),
    .push_i     (keep),
    .push_dat_i (push_ent),
    .pop_i      (pop),
    .head_dat_o (head_ent),
    .count_o    (count)
  );

  assign pop      = id_valid && id_ready;
  assign credit   = (CW+1)'(FIFO_DEPTH) - (CW+1)'(count) - (CW+1)'(outst) + (CW+1)'(pop);
  assign imem_req = !rst && !redirect_en && (credit != '0);
  assign imem_addr = fetch_pc_q;
  assign grant    = imem_req && imem_gnt;

  // A response with nothing outstanding is a protocol error and is ignored.
  assign resp     = imem_rvalid && (outst != '0);
  assign drop     = resp && (discard_q != '0);
  assign keep     = resp && (discard_q == '0);
  assign push_ent = '{inst: imem_rdata, pc: pend_pc, pc4: pend_pc + 32'd4};

  assign outst_after = outst - CW'(resp);

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    discard_d  = discard_q - CW'(drop);
    if (redirect_en) begin
      fetch_pc_d = redirect_pc & ~32'h3;
      discard_d  = discard_q - CW'(drop) + outst_after;
    end else if (grant) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      discard_q  <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      discard_q  <= discard_d;
    end
  end

  assign id_valid = (count != '0);
  assign id_inst  = head_ent.inst;
  assign id_pc    = head_ent.pc;
  assign id_pc4   = head_ent.pc4;
endmodule
